// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection sequencer.
//   LIGHT_*  : 2-bit signal-head encodings (01 green, 10 yellow, 11 red)
//   phase_t  : sequencer state codes, also exported on the debug phase port
package traffic_pkg;

  localparam logic [1:0] LIGHT_GREEN  = 2'b01;
  localparam logic [1:0] LIGHT_YELLOW = 2'b10;
  localparam logic [1:0] LIGHT_RED    = 2'b11;

  typedef enum logic [2:0] {
    AllRedA  = 3'd0,
    NsGreen  = 3'd1,
    NsYellow = 3'd2,
    AllRedB  = 3'd3,
    EwGreen  = 3'd4,
    EwYellow = 3'd5,
    PedWalk  = 3'd6
  } phase_t;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times each sequencer phase.
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (wins over reset and decrement)
//   load_val   : value to load
//   en         : decrement enable; the count holds at 0 and never wraps
//   count      : current count
//   zero       : count == 0
module phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] count_q;

  // Load outranks reset so the parent can choose the value the count takes in reset.
  always_ff @(posedge clk) begin
    if (load) begin
      count_q <= load_val;
    end else if (reset) begin
      count_q <= '0;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// Two-way intersection sequencer: NS/EW signal heads plus a pedestrian WALK phase.
//   clk, reset     : clock, synchronous active-high reset
//   ns_car, ew_car : vehicle present on the NS / EW approach (level)
//   ped_req        : pedestrian button, latched into a pending request
//   ped_ack        : one-cycle pulse on the first cycle of WALK
//   ped_walk       : WALK lamp
//   ns_light       : NS head (01 green, 10 yellow, 11 red)
//   ew_light       : EW head, same encoding
//   phase          : current state code
module traffic_intersection_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_CYC  = 8,
  parameter int unsigned YELLOW_CYC = 3,
  parameter int unsigned ALLRED_CYC = 2,
  parameter int unsigned PED_CYC    = 5,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ns_car,
  input  logic       ew_car,
  input  logic       ped_req,
  output logic       ped_ack,
  output logic       ped_walk,
  output logic [1:0] ns_light,
  output logic [1:0] ew_light,
  output logic [2:0] phase
);

  phase_t           state_q, state_d;
  logic             ped_pending_q;
  logic             ped_ret_q;      // 0: walk came from ALLRED_A, 1: from ALLRED_B
  logic             ped_ack_q;
  logic             enter_walk;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_val;
  logic [CNT_W-1:0] timer_count;
  logic             timer_zero;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_phase_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_load_val),
    .en       (timer_count != '0),
    .count    (timer_count),
    .zero     (timer_zero)
  );

  // Next state. Green states rest at timer==0 until a conflicting demand appears.
  always_comb begin
    state_d = state_q;
    case (state_q)
      AllRedA:  if (timer_zero) state_d = ped_pending_q ? PedWalk : NsGreen;
      NsGreen:  if (timer_zero && (ew_car || ped_pending_q)) state_d = NsYellow;
      NsYellow: if (timer_zero) state_d = AllRedB;
      AllRedB:  if (timer_zero) state_d = ped_pending_q ? PedWalk : EwGreen;
      EwGreen:  if (timer_zero && (ns_car || ped_pending_q)) state_d = EwYellow;
      EwYellow: if (timer_zero) state_d = AllRedA;
      PedWalk:  if (timer_zero) state_d = ped_ret_q ? EwGreen : NsGreen;
      default:  state_d = AllRedA;
    endcase
  end

  assign enter_walk = (state_d == PedWalk) && (state_q != PedWalk);

  // Timer reloads on every state change; during reset it is primed for ALLRED_A.
  always_comb begin
    timer_load = reset || (state_d != state_q);
    case (state_d)
      NsGreen, EwGreen:   timer_load_val = CNT_W'(GREEN_CYC - 1);
      NsYellow, EwYellow: timer_load_val = CNT_W'(YELLOW_CYC - 1);
      PedWalk:            timer_load_val = CNT_W'(PED_CYC - 1);
      default:            timer_load_val = CNT_W'(ALLRED_CYC - 1);
    endcase
    if (reset) timer_load_val = CNT_W'(ALLRED_CYC - 1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= AllRedA;
      ped_pending_q <= 1'b0;
      ped_ret_q     <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ped_ack_q <= enter_walk;
      if (enter_walk) begin
        ped_ret_q <= (state_q == AllRedB);
      end
      // Clearing on walk entry wins over a simultaneous button press.
      if (enter_walk) begin
        ped_pending_q <= 1'b0;
      end else if (ped_req && (state_q != PedWalk)) begin
        ped_pending_q <= 1'b1;
      end
    end
  end

  always_comb begin
    ns_light = LIGHT_RED;
    ew_light = LIGHT_RED;
    ped_walk = 1'b0;
    case (state_q)
      NsGreen:  ns_light = LIGHT_GREEN;
      NsYellow: ns_light = LIGHT_YELLOW;
      EwGreen:  ew_light = LIGHT_GREEN;
      EwYellow: ew_light = LIGHT_YELLOW;
      PedWalk:  ped_walk = 1'b1;
      default:  ;
    endcase
  end

  assign ped_ack = ped_ack_q;
  assign phase   = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
module tb_traffic_intersection_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ns_car = 1'b0;
  logic       ew_car = 1'b0;
  logic       ped_req = 1'b0;
  logic       ped_ack;
  logic       ped_walk;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic [2:0] phase;

  int n_vec  = 0;
  int n_fail = 0;

  localparam logic [1:0] G = 2'b01;
  localparam logic [1:0] Y = 2'b10;
  localparam logic [1:0] R = 2'b11;

  traffic_intersection_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .ns_car   (ns_car),
    .ew_car   (ew_car),
    .ped_req  (ped_req),
    .ped_ack  (ped_ack),
    .ped_walk (ped_walk),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .phase    (phase)
  );

  always #5 clk = ~clk;

  // Safety monitor, sampled on the falling edge.
  logic [1:0] prev_ns = 2'b11;
  logic [1:0] prev_ew = 2'b11;
  always @(negedge clk) begin
    if (reset) begin
      prev_ns = R;
      prev_ew = R;
    end else begin
      n_vec++;
      if (ns_light !== R && ew_light !== R) begin
        n_fail++;
        $display("FAIL safety_conflict: ns=%b ew=%b, required one head 11", ns_light, ew_light);
      end
      if (ped_walk === 1'b1 && (ns_light !== R || ew_light !== R)) begin
        n_fail++;
        $display("FAIL safety_walk: ns=%b ew=%b with walk, required 11/11", ns_light, ew_light);
      end
      if ((prev_ns === G && ns_light === R) || (prev_ew === G && ew_light === R)) begin
        n_fail++;
        $display("FAIL safety_skip_yellow: ns %b->%b ew %b->%b, required 01->10",
                 prev_ns, ns_light, prev_ew, ew_light);
      end
      prev_ns = ns_light;
      prev_ew = ew_light;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 (first cycle after reset deasserts).
  task automatic do_reset();
    reset   = 1'b1;
    ns_car  = 1'b0;
    ew_car  = 1'b0;
    ped_req = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_vec++;
    if (ns_light !== R || ew_light !== R) begin
      n_fail++;
      $display("FAIL reset_lights: ns=%b ew=%b, required 11/11", ns_light, ew_light);
    end
    n_vec++;
    if (ped_walk !== 1'b0 || ped_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ped: walk=%b ack=%b, required 0/0", ped_walk, ped_ack);
    end
    n_vec++;
    if (phase !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_phase: phase=%0d, required 0", phase);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    logic [1:0] en;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      en = (c < 2) ? R : G;
      n_vec++;
      if (ns_light !== en || ew_light !== R || ped_walk !== 1'b0) begin
        n_fail++;
        $display("FAIL idle c%0d: ns=%b ew=%b walk=%b, required %b/11/0",
                 c, ns_light, ew_light, ped_walk, en);
      end
      if (c == 2) begin
        n_vec++;
        if (phase !== 3'd1) begin
          n_fail++;
          $display("FAIL idle_phase: phase=%0d, required 1", phase);
        end
      end
      step();
    end
  endtask

  task automatic test_cars();
    logic [1:0] en, ee;
    logic [2:0] ep;
    int m;
    do_reset();
    ns_car = 1'b1;
    ew_car = 1'b1;
    for (int c = 0; c < 60; c++) begin
      m = (c - 2) % 26;
      if (c < 2)       begin en = R; ee = R; ep = 3'd0; end
      else if (m < 8)  begin en = G; ee = R; ep = 3'd1; end
      else if (m < 11) begin en = Y; ee = R; ep = 3'd2; end
      else if (m < 13) begin en = R; ee = R; ep = 3'd3; end
      else if (m < 21) begin en = R; ee = G; ep = 3'd4; end
      else if (m < 24) begin en = R; ee = Y; ep = 3'd5; end
      else             begin en = R; ee = R; ep = 3'd0; end
      n_vec++;
      if (ns_light !== en || ew_light !== ee || phase !== ep) begin
        n_fail++;
        $display("FAIL cars c%0d: ns=%b ew=%b phase=%0d, required %b/%b/%0d",
                 c, ns_light, ew_light, phase, en, ee, ep);
      end
      step();
    end
  endtask

  task automatic test_ped_pulse();
    logic [1:0] en, ee;
    logic       ew, ea;
    do_reset();
    for (int c = 0; c < 35; c++) begin
      ped_req = (c == 4);
      ew = (c >= 15 && c < 20);
      ea = (c == 15);
      if (c < 2)       begin en = R; ee = R; end
      else if (c < 10) begin en = G; ee = R; end
      else if (c < 13) begin en = Y; ee = R; end
      else if (c < 20) begin en = R; ee = R; end
      else             begin en = R; ee = G; end
      n_vec++;
      if (ns_light !== en || ew_light !== ee || ped_walk !== ew || ped_ack !== ea) begin
        n_fail++;
        $display("FAIL ped_pulse c%0d: ns=%b ew=%b walk=%b ack=%b, required %b/%b/%b/%b",
                 c, ns_light, ew_light, ped_walk, ped_ack, en, ee, ew, ea);
      end
      if (c == 15) begin
        n_vec++;
        if (phase !== 3'd6) begin
          n_fail++;
          $display("FAIL ped_pulse_phase: phase=%0d, required 6", phase);
        end
      end
      step();
    end
    ped_req = 1'b0;
  endtask

  task automatic test_ped_held();
    logic [1:0] en, ee;
    logic       ew, ea;
    int         acks = 0;
    do_reset();
    for (int c = 0; c < 46; c++) begin
      ped_req = (c >= 3 && c <= 20);
      ew = (c >= 15 && c < 20) || (c >= 33 && c < 38);
      ea = (c == 15) || (c == 33);
      if (c < 2)       begin en = R; ee = R; end
      else if (c < 10) begin en = G; ee = R; end
      else if (c < 13) begin en = Y; ee = R; end
      else if (c < 20) begin en = R; ee = R; end
      else if (c < 28) begin en = R; ee = G; end
      else if (c < 31) begin en = R; ee = Y; end
      else if (c < 38) begin en = R; ee = R; end
      else             begin en = G; ee = R; end
      if (c >= 15 && c < 20 && ped_ack === 1'b1) acks++;
      n_vec++;
      if (ns_light !== en || ew_light !== ee || ped_walk !== ew || ped_ack !== ea) begin
        n_fail++;
        $display("FAIL ped_held c%0d: ns=%b ew=%b walk=%b ack=%b, required %b/%b/%b/%b",
                 c, ns_light, ew_light, ped_walk, ped_ack, en, ee, ew, ea);
      end
      step();
    end
    ped_req = 1'b0;
    n_vec++;
    if (acks != 1) begin
      n_fail++;
      $display("FAIL ped_held_ack_count: %0d acks in first walk, required 1", acks);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] en;
    do_reset();
    ns_car = 1'b1;
    ew_car = 1'b1;
    for (int c = 0; c < 24; c++) step();
    n_vec++;
    if (ew_light !== Y || phase !== 3'd5) begin
      n_fail++;
      $display("FAIL mid_pre: ew=%b phase=%0d, required 10/5", ew_light, phase);
    end
    reset = 1'b1;
    step();
    n_vec++;
    if (ns_light !== R || ew_light !== R || phase !== 3'd0 || ped_walk !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: ns=%b ew=%b phase=%0d walk=%b, required 11/11/0/0",
               ns_light, ew_light, phase, ped_walk);
    end
    ns_car = 1'b0;
    ew_car = 1'b0;
    reset  = 1'b0;
    for (int c = 0; c < 14; c++) begin
      en = (c < 2) ? R : G;
      n_vec++;
      if (ns_light !== en || ew_light !== R) begin
        n_fail++;
        $display("FAIL mid_restart c%0d: ns=%b ew=%b, required %b/11", c, ns_light, ew_light, en);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_cars();
    test_ped_pulse();
    test_ped_held();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
